// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scanner: FSM encoding, decoder enable codes, index width.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  localparam logic [2:0] G_ON  = 3'b001;
  localparam logic [2:0] G_OFF = 3'b110;
  localparam int         IDX_W = 3;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/blank down-counter: loads a value, counts to zero, flags terminal count.
// tc is a pure function of the counter register; load takes effect at the next edge.
module scan_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed digit scanner feeding a 3-to-8 decoder, with a frame-synchronous double-buffered display word.
// All outputs come straight from registers; no flow control, writes are accepted every cycle.
module digit_scan_driver
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int BLANK = 1,
  parameter int NDIG  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic [2:0]  g,
  output logic [3:0]  nib,
  output logic        frame,
  output logic        pending
);

  localparam int CW = $clog2(max2(DIV, BLANK) + 1);
  localparam logic [CW-1:0]    DIV_LD   = CW'(DIV - 1);
  localparam logic [CW-1:0]    BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      active_q, active_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             frame_q, frame_d;
  logic [2:0]       g_q, g_d;

  logic             tmr_load;
  logic [CW-1:0]    tmr_val;
  logic             tmr_tc;
  logic             commit;
  logic             wrap;

  scan_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    commit   = 1'b0;
    wrap     = 1'b0;

    // Dropping en overrides everything, whatever the current phase.
    if (!en) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SHOW;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = DIV_LD;
          commit   = 1'b1;
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            wrap     = (idx_q == LAST_IDX);
            idx_d    = wrap ? '0 : idx_q + 1'b1;
            frame_d  = wrap;
            commit   = wrap;
            tmr_load = 1'b1;
            if (BLANK > 0) begin
              state_d = ST_BLANK;
              tmr_val = BLANK_LD;
            end else begin
              tmr_val = DIV_LD;
            end
          end
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = DIV_LD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end

    g_d = (state_d == ST_SHOW) ? G_ON : G_OFF;
  end

  // A write landing on a commit edge bypasses the shadow so it is visible this frame.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (commit) begin
      if (wr) begin
        active_d  = wdata;
        shadow_d  = wdata;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (wr) begin
      shadow_d  = wdata;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      g_q       <= G_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      g_q       <= g_d;
    end
  end

  assign {c, b, a} = idx_q;
  assign g         = g_q;
  assign nib       = active_q[{idx_q, 2'b00} +: 4];
  assign frame     = frame_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Bench for digit_scan_driver: two instances (default and NDIG=3/BLANK=0/DIV=2) against a time-based model.
module tb_digit_scan_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [31:0] wdata;

  logic        a0, b0, c0, fr0, pd0;
  logic [2:0]  g0;
  logic [3:0]  nb0;
  logic        a1, b1, c1, fr1, pd1;
  logic [2:0]  g1;
  logic [3:0]  nb1;

  int n_chk  = 0;
  int n_pass = 0;

  digit_scan_driver u0 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wdata(wdata),
    .a(a0), .b(b0), .c(c0), .g(g0), .nib(nb0), .frame(fr0), .pending(pd0)
  );

  digit_scan_driver #(.DIV(2), .BLANK(0), .NDIG(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wdata(wdata),
    .a(a1), .b(b1), .c(c1), .g(g1), .nib(nb1), .frame(fr1), .pending(pd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: scanning time t counted from the enabling edge; position derived by arithmetic.
  int          PD[2] = '{4, 2};
  int          PB[2] = '{1, 0};
  int          PN[2] = '{8, 3};
  bit          m_run[2];
  int          m_t[2];
  logic [31:0] m_active[2];
  logic [31:0] m_shadow[2];
  bit          m_pend[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] = 0; m_t[i] = 0; m_active[i] = '0; m_shadow[i] = '0; m_pend[i] = 0;
      end else begin
        bit cm;
        cm = 0;
        if (!en) begin
          m_run[i] = 0; m_t[i] = 0;
        end else if (!m_run[i]) begin
          m_run[i] = 1; m_t[i] = 0; cm = 1;
        end else begin
          m_t[i] = m_t[i] + 1;
          cm = ((m_t[i] + PB[i]) % (PN[i] * (PD[i] + PB[i]))) == 0;
        end
        if (cm) begin
          if (wr) begin
            m_active[i] = wdata; m_shadow[i] = wdata; m_pend[i] = 0;
          end else if (m_pend[i]) begin
            m_active[i] = m_shadow[i]; m_pend[i] = 0;
          end
        end else if (wr) begin
          m_shadow[i] = wdata; m_pend[i] = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cmp(input int i, input logic [2:0] g, input logic [2:0] abc, input logic [3:0] nb,
                     input logic fr, input logic pd);
    int per, slot, idx;
    logic [2:0] eg;
    logic ef;
    per  = PN[i] * (PD[i] + PB[i]);
    slot = PD[i] + PB[i];
    if (m_run[i]) begin
      eg  = ((m_t[i] % slot) < PD[i]) ? 3'b001 : 3'b110;
      idx = ((m_t[i] + PB[i]) / slot) % PN[i];
      ef  = (m_t[i] > 0) && (((m_t[i] + PB[i]) % per) == 0);
    end else begin
      eg = 3'b110; idx = 0; ef = 1'b0;
    end
    chk($sformatf("u%0d_g", i), {29'd0, g}, {29'd0, eg});
    chk($sformatf("u%0d_idx", i), {29'd0, abc}, idx);
    chk($sformatf("u%0d_nib", i), {28'd0, nb}, (m_active[i] >> (4 * idx)) & 32'hF);
    chk($sformatf("u%0d_frame", i), {31'd0, fr}, {31'd0, ef});
    chk($sformatf("u%0d_pending", i), {31'd0, pd}, {31'd0, m_pend[i]});
  endtask

  function automatic logic [7:0] dec38(input logic [2:0] s, input logic [2:0] ge);
    logic [7:0] o;
    o = 8'hFF;
    if (ge[0] && !ge[1] && !ge[2]) o[s] = 1'b0;
    return o;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, g0, {c0, b0, a0}, nb0, fr0, pd0);
      cmp(1, g1, {c1, b1, a1}, nb1, fr1, pd1);
    end
  end

  task automatic goto(input int tt);
    int k;
    k = 0;
    while (!(m_run[0] && m_t[0] == tt) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_chk++;
      $display("FAIL goto_timeout: t=%0d never reached", tt);
    end
    #1;
  endtask

  initial begin
    logic [2:0] seq1[7];
    logic [7:0] exp_o;
    seq1 = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0};
    rst = 1'b1; en = 1'b0; wr = 1'b0; wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_g", {29'd0, g0}, 32'd6);
    chk("rst_abc", {29'd0, c0, b0, a0}, 32'd0);
    chk("rst_pend", {31'd0, pd0}, 32'd0);
    rst = 1'b0;

    @(negedge clk); wr = 1'b1; wdata = 32'h76543210;
    @(negedge clk); wr = 1'b0; en = 1'b1;
    #1 chk("pend_before_en", {31'd0, pd0}, 32'd1);

    for (int tt = 0; tt < 7; tt++) begin
      goto(tt);
      chk("u1_seq_idx", {29'd0, c1, b1, a1}, {29'd0, seq1[tt]});
      chk("u1_g_on", {29'd0, g1}, 32'd1);
      chk("u1_frame6", {31'd0, fr1}, (tt == 6) ? 32'd1 : 32'd0);
      if (tt == 0) begin
        chk("d0_g", {29'd0, g0}, 32'd1);
        chk("d0_nib", {28'd0, nb0}, 32'd0);
        chk("d0_pend", {31'd0, pd0}, 32'd0);
      end
      if (tt == 4) begin
        chk("blank_g", {29'd0, g0}, 32'd6);
        chk("blank_idx", {29'd0, c0, b0, a0}, 32'd1);
      end
      if (tt == 5) begin
        exp_o = 8'hFD;
        chk("d1_nib", {28'd0, nb0}, 32'd1);
        chk("d1_dec", {24'd0, dec38({c0, b0, a0}, g0)}, {24'd0, exp_o});
      end
    end
    goto(39); chk("frame39", {31'd0, fr0}, 32'd1);
    goto(40); chk("frame40", {31'd0, fr0}, 32'd0);

    goto(56); wr = 1'b1; wdata = 32'hFFFF0000;
    @(negedge clk); wr = 1'b0;
    goto(60); chk("t3_nib_old", {28'd0, nb0}, 32'd4); chk("t3_pend", {31'd0, pd0}, 32'd1);
    goto(80); chk("t3_nib0", {28'd0, nb0}, 32'd0); chk("t3_pend0", {31'd0, pd0}, 32'd0);
    goto(100); chk("t3_nib4", {28'd0, nb0}, 32'hF);

    goto(118); wr = 1'b1; wdata = 32'hAAAAAAAA;
    @(negedge clk); wr = 1'b0;
    #1 chk("t4_pend", {31'd0, pd0}, 32'd0); chk("t4_frame", {31'd0, fr0}, 32'd1);
    goto(120); chk("t4_nibA", {28'd0, nb0}, 32'hA);

    goto(146); en = 1'b0;
    @(negedge clk); #1;
    chk("t6_g_off", {29'd0, g0}, 32'd6); chk("t6_idx0", {29'd0, c0, b0, a0}, 32'd0);
    @(negedge clk); en = 1'b1;
    for (int tt = 0; tt < 5; tt++) begin
      goto(tt);
      chk("t6_dwell", {29'd0, g0}, (tt < 4) ? 32'd1 : 32'd6);
    end

    goto(26);
    #2 rst = 1'b1;
    #1;
    chk("t1_g", {29'd0, g0}, 32'd6);
    chk("t1_abc", {29'd0, c0, b0, a0}, 32'd0);
    chk("t1_nib", {28'd0, nb0}, 32'd0);
    chk("t1_frame", {31'd0, fr0}, 32'd0);
    chk("t1_pend", {31'd0, pd0}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 31) != 0);
      wr    = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
